// File: rtl/ptw_walker_pkg.sv
// Shared types and constants for the Sv39 page-table walker: walk states,
// PTE field positions, VA/VPN slicing and the per-level VPN select helper.
package ptw_walker_pkg;

  localparam int VIRTUAL_ADDR_LEN_SV39  = 39;
  localparam int PHYSICAL_ADDR_LEN_SV39 = 56;
  localparam int PTE_SIZE_IN_BIT        = 64;
  localparam int SATP_PPN_WIDTH         = 44;
  localparam int PAGE_OFFSET_WIDTH      = 12;
  localparam int VPN_SLICE_WIDTH        = 9;

  localparam int VPN_W       = VIRTUAL_ADDR_LEN_SV39 - PAGE_OFFSET_WIDTH;
  localparam int VA_VPN_LSB  = PAGE_OFFSET_WIDTH;
  localparam int VA_VPN_MSB  = VIRTUAL_ADDR_LEN_SV39 - 1;
  localparam int VPN0_LSB    = 0;
  localparam int VPN1_LSB    = VPN_SLICE_WIDTH;
  localparam int VPN2_LSB    = 2 * VPN_SLICE_WIDTH;

  localparam int PTE_V       = 0;
  localparam int PTE_R       = 1;
  localparam int PTE_W       = 2;
  localparam int PTE_X       = 3;
  localparam int PTE_PPN_LSB = 10;
  localparam int PTE_PPN_MSB = 53;

  localparam int PTE_ENTRY_SHIFT = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE,
    ST_FAULT,
    ST_DRAIN
  } walk_state_e;

  typedef enum logic [1:0] {
    PTE_LEAF,
    PTE_POINTER,
    PTE_FAULT
  } pte_class_e;

  function automatic logic [VPN_SLICE_WIDTH-1:0] vpn_slice(
    input logic [VPN_W-1:0] vpn,
    input logic [1:0]       level
  );
    logic [VPN_SLICE_WIDTH-1:0] s;
    case (level)
      2'd2:    s = vpn[VPN2_LSB +: VPN_SLICE_WIDTH];
      2'd1:    s = vpn[VPN1_LSB +: VPN_SLICE_WIDTH];
      default: s = vpn[VPN0_LSB +: VPN_SLICE_WIDTH];
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ptw_walker_if.sv
// Walker-facing bundle: TLB miss request, flush, PTE memory port and refill/fault results.
// master = the walker, slave = the TLB/memory environment around it.
interface ptw_walker_if;
  import ptw_walker_pkg::*;

  logic                              walk_req_valid_i;
  logic                              walk_req_ready_o;
  logic [VIRTUAL_ADDR_LEN_SV39-1:0]  walk_req_vaddr_i;
  logic [SATP_PPN_WIDTH-1:0]         satp_ppn_i;
  logic                              flush_i;
  logic                              mem_req_valid_o;
  logic                              mem_req_ready_i;
  logic [PHYSICAL_ADDR_LEN_SV39-1:0] mem_req_addr_o;
  logic                              mem_resp_valid_i;
  logic [PTE_SIZE_IN_BIT-1:0]        mem_resp_data_i;
  logic                              refill_valid_o;
  logic [VPN_W-1:0]                  refill_vpn_o;
  logic [PTE_SIZE_IN_BIT-1:0]        refill_pte_o;
  logic [1:0]                        refill_level_o;
  logic                              page_fault_o;

  modport master (
    input  walk_req_valid_i, walk_req_vaddr_i, satp_ppn_i, flush_i,
           mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i,
    output walk_req_ready_o, mem_req_valid_o, mem_req_addr_o,
           refill_valid_o, refill_vpn_o, refill_pte_o, refill_level_o, page_fault_o
  );

  modport slave (
    output walk_req_valid_i, walk_req_vaddr_i, satp_ppn_i, flush_i,
           mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i,
    input  walk_req_ready_o, mem_req_valid_o, mem_req_addr_o,
           refill_valid_o, refill_vpn_o, refill_pte_o, refill_level_o, page_fault_o
  );

endinterface

// File: rtl/ptw_walker_pte_decode.sv
// Combinational Sv39 PTE classifier (leaf / pointer / fault) for one walk level.
// PTW_SUPERPAGE_EN enables level-2/1 leaves with their PPN alignment check.
module ptw_pte_decode
  import ptw_walker_pkg::*;
(
  input  logic [PTE_SIZE_IN_BIT-1:0] pte_i,
  input  logic [1:0]                 level_i,
  output pte_class_e                 class_o
);

  logic v, r, w, x;
  logic leaf_ok;
  logic unused_bits;

  assign v = pte_i[PTE_V];
  assign r = pte_i[PTE_R];
  assign w = pte_i[PTE_W];
  assign x = pte_i[PTE_X];

`ifdef PTW_SUPERPAGE_EN
  // Superpage PPN must be aligned to the span it maps: 2^18 pages at level 2, 2^9 at level 1.
  always_comb begin
    leaf_ok = 1'b0;
    case (level_i)
      2'd0:    leaf_ok = 1'b1;
      2'd1:    leaf_ok = (pte_i[PTE_PPN_LSB +: VPN_SLICE_WIDTH] == '0);
      2'd2:    leaf_ok = (pte_i[PTE_PPN_LSB +: 2*VPN_SLICE_WIDTH] == '0);
      default: leaf_ok = 1'b0;
    endcase
  end
  assign unused_bits = ^{pte_i[PTE_SIZE_IN_BIT-1:PTE_PPN_LSB+2*VPN_SLICE_WIDTH],
                         pte_i[PTE_PPN_LSB-1:PTE_X+1]};
`else
  assign leaf_ok     = (level_i == 2'd0);
  assign unused_bits = ^pte_i[PTE_SIZE_IN_BIT-1:PTE_X+1];
`endif

  always_comb begin
    class_o = PTE_FAULT;
    if (!v) begin
      class_o = PTE_FAULT;
    end else if (!r && w) begin
      class_o = PTE_FAULT;
    end else if (r || x) begin
      class_o = leaf_ok ? PTE_LEAF : PTE_FAULT;
    end else begin
      class_o = (level_i == 2'd0) ? PTE_FAULT : PTE_POINTER;
    end
  end

endmodule

// File: rtl/ptw_walker.sv
// Sequential Sv39 page-table walker: one miss at a time, up to three PTE reads,
// ending in a single refill or page-fault pulse. Superpages via PTW_SUPERPAGE_EN.
module ptw_walker
  import ptw_walker_pkg::*;
(
  input  logic         clk,
  input  logic         rstn,
  ptw_walker_if.master bus
);

  walk_state_e                       state_q;
  logic [VPN_W-1:0]                  vpn_q;
  logic [SATP_PPN_WIDTH-1:0]         ppn_q;
  logic [1:0]                        level_q;
  logic                              req_valid_q;
  logic                              refill_q;
  logic                              fault_q;
  logic [VPN_W-1:0]                  out_vpn_q;
  logic [PTE_SIZE_IN_BIT-1:0]        out_pte_q;
  logic [1:0]                        out_level_q;

  logic [VPN_SLICE_WIDTH-1:0]        vpn_cur;
  logic [PHYSICAL_ADDR_LEN_SV39-1:0] req_addr;
  pte_class_e                        pte_class;
  logic                              unused_va;

  assign unused_va = ^bus.walk_req_vaddr_i[VA_VPN_LSB-1:0];

  // Entry offset never exceeds the 4 KiB page, so the sum cannot carry past bit 55.
  assign vpn_cur  = vpn_slice(vpn_q, level_q);
  assign req_addr = {ppn_q, {PAGE_OFFSET_WIDTH{1'b0}}}
                  + {{(PHYSICAL_ADDR_LEN_SV39-VPN_SLICE_WIDTH-PTE_ENTRY_SHIFT){1'b0}},
                     vpn_cur, {PTE_ENTRY_SHIFT{1'b0}}};

  ptw_pte_decode u_pte_decode (
    .pte_i   (bus.mem_resp_data_i),
    .level_i (level_q),
    .class_o (pte_class)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      vpn_q       <= '0;
      ppn_q       <= '0;
      level_q     <= '0;
      req_valid_q <= 1'b0;
      refill_q    <= 1'b0;
      fault_q     <= 1'b0;
      out_vpn_q   <= '0;
      out_pte_q   <= '0;
      out_level_q <= '0;
    end else begin
      refill_q <= 1'b0;
      fault_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.walk_req_valid_i) begin
            vpn_q       <= bus.walk_req_vaddr_i[VA_VPN_MSB:VA_VPN_LSB];
            ppn_q       <= bus.satp_ppn_i;
            level_q     <= 2'd2;
            req_valid_q <= 1'b1;
            state_q     <= ST_REQ;
          end
        end
        ST_REQ: begin
          // A flush that coincides with the handshake still owes us a response.
          if (bus.flush_i) begin
            req_valid_q <= 1'b0;
            state_q     <= bus.mem_req_ready_i ? ST_DRAIN : ST_IDLE;
          end else if (bus.mem_req_ready_i) begin
            req_valid_q <= 1'b0;
            state_q     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.flush_i) begin
            state_q <= bus.mem_resp_valid_i ? ST_IDLE : ST_DRAIN;
          end else if (bus.mem_resp_valid_i) begin
            unique case (pte_class)
              PTE_LEAF: begin
                out_vpn_q   <= vpn_q;
                out_pte_q   <= bus.mem_resp_data_i;
                out_level_q <= level_q;
                refill_q    <= 1'b1;
                state_q     <= ST_DONE;
              end
              PTE_POINTER: begin
                level_q     <= level_q - 2'd1;
                ppn_q       <= bus.mem_resp_data_i[PTE_PPN_MSB:PTE_PPN_LSB];
                req_valid_q <= 1'b1;
                state_q     <= ST_REQ;
              end
              default: begin
                out_vpn_q   <= vpn_q;
                out_level_q <= level_q;
                fault_q     <= 1'b1;
                state_q     <= ST_FAULT;
              end
            endcase
          end
        end
        ST_DONE, ST_FAULT: begin
          state_q <= ST_IDLE;
        end
        ST_DRAIN: begin
          if (bus.mem_resp_valid_i) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.walk_req_ready_o = (state_q == ST_IDLE);
  assign bus.mem_req_valid_o  = req_valid_q;
  assign bus.mem_req_addr_o   = req_addr;
  assign bus.refill_valid_o   = refill_q & ~bus.flush_i;
  assign bus.page_fault_o     = fault_q & ~bus.flush_i;
  assign bus.refill_vpn_o     = out_vpn_q;
  assign bus.refill_pte_o     = out_pte_q;
  assign bus.refill_level_o   = out_level_q;

endmodule
